// File: rtl/romulus_pdo_serializer_if.sv
// Block-in / word-out handshake bundle for the Romulus PDO serializer.
// The slave side is the serializer. The master side is the datapath plus the downstream word sink.
interface romulus_pdo_serializer_if;
  logic [127:0] pdo;
  logic         pdo_valid;
  logic         pdo_last;
  logic [4:0]   pdo_bytes;
  logic         pdo_ready;
  logic [31:0]  do_data;
  logic         do_valid;
  logic         do_last;
  logic         do_ready;

  modport master (
    output pdo, pdo_valid, pdo_last, pdo_bytes, do_ready,
    input  pdo_ready, do_data, do_valid, do_last
  );
  modport slave (
    input  pdo, pdo_valid, pdo_last, pdo_bytes, do_ready,
    output pdo_ready, do_data, do_valid, do_last
  );
endinterface

// File: rtl/romulus_pdo_serializer.sv
// Splits 128-bit PDO blocks into MSB-first 32-bit words, with no bubble between blocks.
// Define ROMULUS_PDO_ZEROPAD_EN to zero the bytes of the final word that lie past the byte count.
module romulus_pdo_serializer (
  input logic                     clk,
  input logic                     rst,
  romulus_pdo_serializer_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_q, state_n;
  logic [NUM_LANES-1:0][31:0]     blk_q;
  logic                           last_q;
  logic [1:0]                     idx_q;
  logic [2:0]                     wcnt_q;
`ifdef ROMULUS_PDO_ZEROPAD_EN
  logic [4:0]                     bcnt_q;
`endif

  logic [4:0]                     bcnt_eff;
  logic [2:0]                     wcnt_eff;
  logic                           send, fin_word, consume, accept;
  logic [NUM_LANES-1:0][7:0]      word_raw, word_out;

  // Non-final blocks and out-of-range counts always carry a full 16 bytes.
  always_comb begin
    bcnt_eff = bus.pdo_bytes;
    if (!bus.pdo_last || bus.pdo_bytes == 5'd0 || bus.pdo_bytes > 5'd16)
      bcnt_eff = 5'd16;
    wcnt_eff = bcnt_eff[4:2] + {2'b00, |bcnt_eff[1:0]};
  end

  assign send          = (state_q == SEND) && !rst;
  assign fin_word      = ({1'b0, idx_q} == wcnt_q - 3'd1);
  assign consume       = send && bus.do_ready;
  assign bus.pdo_ready = !rst && ((state_q == IDLE) || (consume && fin_word));
  assign accept        = bus.pdo_valid && bus.pdo_ready;

  always_comb begin
    state_n      = state_q;
    bus.do_valid = send;
    bus.do_last  = send && last_q && fin_word;
    case (state_q)
      IDLE:    if (accept) state_n = SEND;
      SEND:    if (consume && fin_word && !accept) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
      wcnt_q  <= 3'd0;
`ifdef ROMULUS_PDO_ZEROPAD_EN
      bcnt_q  <= 5'd0;
`endif
    end else begin
      state_q <= state_n;
      if (accept) begin
        blk_q   <= bus.pdo;
        last_q  <= bus.pdo_last;
        idx_q   <= 2'd0;
        wcnt_q  <= wcnt_eff;
`ifdef ROMULUS_PDO_ZEROPAD_EN
        bcnt_q  <= bcnt_eff;
`endif
      end else if (consume) begin
        idx_q   <= idx_q + 2'd1;
      end
    end
  end

  // Word k sits in packed slot 3-k, so index 0 is bits [127:96].
  assign word_raw = blk_q[2'd3 - idx_q];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
`ifdef ROMULUS_PDO_ZEROPAD_EN
    localparam logic [1:0] OFS = 2'(NUM_LANES - 1 - l);
    logic [4:0] pos;
    assign pos         = {1'b0, idx_q, OFS};
    assign word_out[l] = (pos < bcnt_q) ? word_raw[l] : 8'h00;
`else
    assign word_out[l] = word_raw[l];
`endif
  end

  assign bus.do_data = send ? word_out : 32'h0;
endmodule

// File: tb/tb_romulus_pdo_serializer.sv
// Directed bench for romulus_pdo_serializer: full, partial, back-to-back, stall, reset and odd byte counts.
module tb_romulus_pdo_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  romulus_pdo_serializer_if bus ();

  romulus_pdo_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
`ifdef ROMULUS_PDO_ZEROPAD_EN
  localparam logic [31:0] PART_W1 = 32'h44550000;
`else
  localparam logic [31:0] PART_W1 = 32'h44556677;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a block while idle; it must be taken in this cycle.
  task automatic offer(input string tag, input logic [127:0] d, input logic lst, input logic [4:0] n);
    bus.pdo = d; bus.pdo_last = lst; bus.pdo_bytes = n; bus.pdo_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".rdy"}, {31'd0, bus.pdo_ready}, 32'd1);
    chk({tag, ".vld0"}, {31'd0, bus.do_valid}, 32'd0);
    @(posedge clk); #1;
    bus.pdo_valid = 1'b0;
  endtask

  // One consumed word with do_ready high.
  task automatic word(input string tag, input logic [31:0] d, input logic fin, input logic lst);
    @(negedge clk);
    chk({tag, ".vld"},  {31'd0, bus.do_valid},  32'd1);
    chk({tag, ".dat"},  bus.do_data,            d);
    chk({tag, ".last"}, {31'd0, bus.do_last},   {31'd0, fin & lst});
    chk({tag, ".prdy"}, {31'd0, bus.pdo_ready}, {31'd0, fin});
    @(posedge clk); #1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, ".vld"},  {31'd0, bus.do_valid},  32'd0);
    chk({tag, ".prdy"}, {31'd0, bus.pdo_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.pdo = '0; bus.pdo_valid = 1'b0; bus.pdo_last = 1'b0; bus.pdo_bytes = 5'd0;
    bus.do_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.prdy", {31'd0, bus.pdo_ready}, 32'd0);
    chk("rst.vld",  {31'd0, bus.do_valid},  32'd0);
    chk("rst.last", {31'd0, bus.do_last},   32'd0);
    chk("rst.dat",  bus.do_data,            32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_idle("idle0");

    // Full block, one word per cycle, first word one cycle after acceptance.
    offer("full", BLK_A, 1'b1, 5'd16);
    word("full.w0", 32'h00112233, 1'b0, 1'b1);
    word("full.w1", 32'h44556677, 1'b0, 1'b1);
    word("full.w2", 32'h8899AABB, 1'b0, 1'b1);
    word("full.w3", 32'hCCDDEEFF, 1'b1, 1'b1);
    expect_idle("full.end");

    // Six bytes -> two words, second one partial.
    offer("part", BLK_A, 1'b1, 5'd6);
    word("part.w0", 32'h00112233, 1'b0, 1'b1);
    word("part.w1", PART_W1,      1'b1, 1'b1);
    expect_idle("part.end");

    // Byte count is ignored on a non-final block.
    offer("nl6", BLK_A, 1'b0, 5'd6);
    word("nl6.w0", 32'h00112233, 1'b0, 1'b0);
    word("nl6.w1", 32'h44556677, 1'b0, 1'b0);
    word("nl6.w2", 32'h8899AABB, 1'b0, 1'b0);
    word("nl6.w3", 32'hCCDDEEFF, 1'b1, 1'b0);
    expect_idle("nl6.end");

    // Back-to-back: B offered during A's final word, no idle gap.
    offer("b2b", BLK_A, 1'b0, 5'd16);
    word("b2b.a0", 32'h00112233, 1'b0, 1'b0);
    word("b2b.a1", 32'h44556677, 1'b0, 1'b0);
    word("b2b.a2", 32'h8899AABB, 1'b0, 1'b0);
    bus.pdo = BLK_B; bus.pdo_last = 1'b1; bus.pdo_bytes = 5'd16; bus.pdo_valid = 1'b1;
    word("b2b.a3", 32'hCCDDEEFF, 1'b1, 1'b0);
    bus.pdo_valid = 1'b0;
    word("b2b.b0", 32'hDEADBEEF, 1'b0, 1'b1);
    word("b2b.b1", 32'h01234567, 1'b0, 1'b1);
    word("b2b.b2", 32'h89ABCDEF, 1'b0, 1'b1);
    word("b2b.b3", 32'hFEDCBA98, 1'b1, 1'b1);
    expect_idle("b2b.end");

    // Stall at word index 1 for three cycles.
    offer("stall", BLK_A, 1'b1, 5'd16);
    word("stall.w0", 32'h00112233, 1'b0, 1'b1);
    bus.do_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.hold.vld",  {31'd0, bus.do_valid},  32'd1);
      chk("stall.hold.dat",  bus.do_data,            32'h44556677);
      chk("stall.hold.last", {31'd0, bus.do_last},   32'd0);
      chk("stall.hold.prdy", {31'd0, bus.pdo_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.do_ready = 1'b1;
    word("stall.w1", 32'h44556677, 1'b0, 1'b1);
    word("stall.w2", 32'h8899AABB, 1'b0, 1'b1);
    word("stall.w3", 32'hCCDDEEFF, 1'b1, 1'b1);
    expect_idle("stall.end");

    // Reset mid-block with do_ready still high.
    offer("mrst", BLK_A, 1'b1, 5'd16);
    word("mrst.w0", 32'h00112233, 1'b0, 1'b1);
    word("mrst.w1", 32'h44556677, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.vld",  {31'd0, bus.do_valid},  32'd0);
    chk("mrst.prdy", {31'd0, bus.pdo_ready}, 32'd0);
    chk("mrst.dat",  bus.do_data,            32'd0);
    chk("mrst.last", {31'd0, bus.do_last},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_idle("mrst.after");
    offer("mrst.new", BLK_B, 1'b1, 5'd16);
    word("mrst.b0", 32'hDEADBEEF, 1'b0, 1'b1);
    word("mrst.b1", 32'h01234567, 1'b0, 1'b1);
    word("mrst.b2", 32'h89ABCDEF, 1'b0, 1'b1);
    word("mrst.b3", 32'hFEDCBA98, 1'b1, 1'b1);
    expect_idle("mrst.end");

    // Out-of-range counts behave as 16.
    offer("z0", BLK_A, 1'b1, 5'd0);
    word("z0.w0", 32'h00112233, 1'b0, 1'b1);
    word("z0.w1", 32'h44556677, 1'b0, 1'b1);
    word("z0.w2", 32'h8899AABB, 1'b0, 1'b1);
    word("z0.w3", 32'hCCDDEEFF, 1'b1, 1'b1);
    expect_idle("z0.end");
    offer("b20", BLK_A, 1'b1, 5'd20);
    word("b20.w0", 32'h00112233, 1'b0, 1'b1);
    word("b20.w1", 32'h44556677, 1'b0, 1'b1);
    word("b20.w2", 32'h8899AABB, 1'b0, 1'b1);
    word("b20.w3", 32'hCCDDEEFF, 1'b1, 1'b1);
    expect_idle("b20.end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
